// File: rtl/gf10_cnt_seq_ctrl.sv
// gf10_cnt_seq_ctrl: sequences a GF(2^10) counter bank through a Chien-search position sweep
module gf10_cnt_seq_ctrl #(
  parameter int GF_LEN = 10,
  parameter int CW_LEN = 1023
) (
  input  logic              clk,
  input  logic              in_Srst,
  input  logic              in_start,
  input  logic [GF_LEN-1:0] in_first_pos,
  input  logic [GF_LEN-1:0] in_num_pos,
  input  logic              in_abort,
  input  logic              in_out_ready,
  output logic              out_ctr_Srst,
  output logic              out_ctr_en,
  output logic              out_ctr_init,
  output logic              out_valid,
  output logic [GF_LEN-1:0] out_pos_idx,
  output logic              out_last,
  output logic              out_busy,
  output logic              out_done
);
  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
  localparam logic [GF_LEN-1:0] CW = GF_LEN'(CW_LEN);
  localparam logic [GF_LEN-1:0] TOP = GF_LEN'(CW_LEN - 1);
  localparam logic [GF_LEN-1:0] ONE = GF_LEN'(1);
  localparam logic [GF_LEN-1:0] TWO = GF_LEN'(2);
  state_t state;
  logic [GF_LEN-1:0] rem;
  logic kill, xfer, step;
  assign kill = in_abort & out_busy;
  assign xfer = (state == RUN) & in_out_ready;
  assign step = xfer & (rem > ONE);
  assign out_ctr_Srst = in_Srst | kill;
  assign out_ctr_en = !out_ctr_Srst & ((state == INIT) | step);
  assign out_ctr_init = !out_ctr_Srst & (state == INIT);
  // job FSM: latch job, one init cycle, stream positions with handshake, pulse done
  always_ff @(posedge clk) begin
    if (in_Srst) begin
      state <= IDLE;
      out_pos_idx <= '0;
      rem <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      rem <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_start) begin
          out_busy <= 1'b1;
          if (in_num_pos != '0) begin
            state <= INIT;
            out_pos_idx <= (in_first_pos == CW) ? '0 : in_first_pos;
            rem <= (in_num_pos > CW) ? CW : in_num_pos;
          end else begin
            state <= DONE;
            out_done <= 1'b1;
          end
        end
        INIT: begin
          state <= RUN;
          out_valid <= 1'b1;
          out_last <= (rem == ONE);
        end
        RUN: if (xfer) begin
          if (rem > ONE) begin
            out_pos_idx <= (out_pos_idx == TOP) ? '0 : out_pos_idx + ONE;
            rem <= rem - ONE;
            out_last <= (rem == TWO);
          end else begin
            state <= DONE;
            rem <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          out_done <= 1'b0;
          out_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gf10_cnt_seq_ctrl.sv
// tb_gf10_cnt_seq_ctrl: directed vector table plus a full-length sweep for the sequencer
module tb_gf10_cnt_seq_ctrl;
  typedef struct {
    logic [3:0] in_bits;
    logic [9:0] first;
    logic [9:0] num;
    logic [6:0] exp_bits;
    logic [9:0] exp_pos;
  } vec_t;
  logic clk = 1'b0;
  logic srst, start, abort, ready;
  logic [9:0] first, num;
  logic ctr_srst, ctr_en, ctr_init, valid, last, busy, done;
  logic [9:0] pos;
  int n_chk = 0;
  int n_fail = 0;
  vec_t v[$];
  gf10_cnt_seq_ctrl dut (
    .clk(clk), .in_Srst(srst), .in_start(start), .in_first_pos(first),
    .in_num_pos(num), .in_abort(abort), .in_out_ready(ready),
    .out_ctr_Srst(ctr_srst), .out_ctr_en(ctr_en), .out_ctr_init(ctr_init),
    .out_valid(valid), .out_pos_idx(pos), .out_last(last), .out_busy(busy), .out_done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  // in_bits = {srst,start,abort,ready}; exp_bits = {ctr_srst,en,init,valid,last,busy,done}
  function automatic vec_t row(input logic [3:0] ib, input int f, input int nm, input logic [6:0] eb, input int p);
    vec_t r;
    r.in_bits = ib;
    r.first = 10'(f);
    r.num = 10'(nm);
    r.exp_bits = eb;
    r.exp_pos = 10'(p);
    return r;
  endfunction
  initial begin
    int xfers, ens;
    bit got_done;
    v.push_back(row(4'b1000, 0, 0, 7'b1000000, 0));
    v.push_back(row(4'b1000, 0, 0, 7'b1000000, 0));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 0));
    v.push_back(row(4'b0101, 5, 4, 7'b0000000, 0));
    v.push_back(row(4'b0001, 0, 0, 7'b0110010, 5));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 5));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 6));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 7));
    v.push_back(row(4'b0001, 0, 0, 7'b0001110, 8));
    v.push_back(row(4'b0000, 0, 0, 7'b0000011, 8));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 8));
    v.push_back(row(4'b0100, 100, 3, 7'b0000000, 8));
    v.push_back(row(4'b0000, 0, 0, 7'b0110010, 100));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 100));
    v.push_back(row(4'b0000, 0, 0, 7'b0001010, 101));
    v.push_back(row(4'b0000, 0, 0, 7'b0001010, 101));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 101));
    v.push_back(row(4'b0001, 0, 0, 7'b0001110, 102));
    v.push_back(row(4'b0000, 0, 0, 7'b0000011, 102));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 102));
    v.push_back(row(4'b0100, 7, 0, 7'b0000000, 102));
    v.push_back(row(4'b0000, 0, 0, 7'b0000011, 102));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 102));
    v.push_back(row(4'b0101, 10, 3, 7'b0000000, 102));
    v.push_back(row(4'b0001, 0, 0, 7'b0110010, 10));
    v.push_back(row(4'b0101, 500, 9, 7'b0101010, 10));
    v.push_back(row(4'b0101, 500, 9, 7'b0101010, 11));
    v.push_back(row(4'b0101, 500, 9, 7'b0001110, 12));
    v.push_back(row(4'b0000, 0, 0, 7'b0000011, 12));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 12));
    v.push_back(row(4'b0101, 20, 5, 7'b0000000, 12));
    v.push_back(row(4'b0001, 0, 0, 7'b0110010, 20));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 20));
    v.push_back(row(4'b0011, 0, 0, 7'b1001010, 21));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 21));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 21));
    v.push_back(row(4'b0101, 30, 5, 7'b0000000, 21));
    v.push_back(row(4'b0001, 0, 0, 7'b0110010, 30));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 30));
    v.push_back(row(4'b1001, 0, 0, 7'b1001010, 31));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 0));
    v.push_back(row(4'b0101, 1021, 4, 7'b0000000, 0));
    v.push_back(row(4'b0001, 0, 0, 7'b0110010, 1021));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 1021));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 1022));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 0));
    v.push_back(row(4'b0001, 0, 0, 7'b0001110, 1));
    v.push_back(row(4'b0000, 0, 0, 7'b0000011, 1));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 1));
    v.push_back(row(4'b0101, 1023, 2, 7'b0000000, 1));
    v.push_back(row(4'b0001, 0, 0, 7'b0110010, 0));
    v.push_back(row(4'b0001, 0, 0, 7'b0101010, 0));
    v.push_back(row(4'b0001, 0, 0, 7'b0001110, 1));
    v.push_back(row(4'b0000, 0, 0, 7'b0000011, 1));
    v.push_back(row(4'b0000, 0, 0, 7'b0000000, 1));
    v.push_back(row(4'b0010, 0, 0, 7'b0000000, 1));
    srst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; first = '0; num = '0;
    @(negedge clk);
    foreach (v[i]) begin
      @(negedge clk);
      {srst, start, abort, ready} = v[i].in_bits;
      first = v[i].first;
      num = v[i].num;
      #1;
      chk($sformatf("row%0d_flags", i), int'({ctr_srst, ctr_en, ctr_init, valid, last, busy, done}), int'(v[i].exp_bits));
      chk($sformatf("row%0d_pos", i), int'(pos), int'(v[i].exp_pos));
    end
    @(negedge clk);
    {srst, start, abort, ready} = 4'b0101;
    first = 10'd0;
    num = 10'd1023;
    xfers = 0;
    ens = 0;
    got_done = 1'b0;
    for (int c = 0; c < 1100 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      ens += int'(ctr_en);
      if (valid) begin
        chk("full_pos", int'(pos), xfers);
        chk("full_last", int'(last), int'(xfers == 1022));
        xfers++;
      end
      if (done) got_done = 1'b1;
    end
    chk("full_xfers", xfers, 1023);
    chk("full_en_count", ens, 1023);
    chk("full_done_seen", int'(got_done), 1);
    @(negedge clk);
    #1;
    chk("full_idle_busy", int'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
